// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler that owns HI/LO, with a busy countdown that models multi-cycle latency
// and a stall request toward the hazard logic.
module md_sched #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_start_E,
   input  logic [2:0]  md_op_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   input  logic        md_use_D,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall_md
);
   typedef enum logic {IDLE, RUN} state_e;
   state_e             state_q;
   logic [3:0]         cnt_q;
   logic [31:0]        hi_q, lo_q;
   logic [63:0]        res_q, res_d;
   logic               wr_q, wr_d, busy_q, is_md;
   logic [31:0]        sdv, udv, uq, ur;
   logic signed [31:0] sq, sr;
   logic signed [63:0] smul;
   always_comb begin
      // 0x80000000 / -1 is computed as /1, which yields the required wrapped quotient and zero remainder
      sdv = (rt_E == '0 || (rs_E == 32'h8000_0000 && rt_E == 32'hFFFF_FFFF)) ? 32'd1 : rt_E;
      udv = (rt_E == '0) ? 32'd1 : rt_E;
      sq = $signed(rs_E) / $signed(sdv);
      sr = $signed(rs_E) % $signed(sdv);
      uq = rs_E / udv;
      ur = rs_E % udv;
      smul = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
      res_d = (md_op_E == 3'd0) ? smul
            : (md_op_E == 3'd1) ? {32'd0, rs_E} * {32'd0, rt_E}
            : (md_op_E == 3'd2) ? {sr, sq} : {ur, uq};
      wr_d = !(md_op_E[1] && rt_E == '0);
      is_md = md_start_E && !md_op_E[2];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         res_q   <= '0;
         wr_q    <= 1'b0;
      end else if (state_q == IDLE) begin
         if (is_md) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= md_op_E[1] ? 4'(DIV_CYC - 1) : 4'(MULT_CYC - 1);
            res_q   <= res_d;
            wr_q    <= wr_d;
         end else if (md_start_E && md_op_E == 3'd4) hi_q <= rs_E;
         else if (md_start_E && md_op_E == 3'd5) lo_q <= rs_E;
      end else if (cnt_q == '0) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         if (wr_q) {hi_q, lo_q} <= res_q;
      end else cnt_q <= cnt_q - 4'd1;
   end
   assign hi = hi_q;
   assign lo = lo_q;
   assign busy = busy_q;
   assign stall_md = !reset && md_use_D && (busy_q || is_md);
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed-vector bench for md_sched, one task per scenario with inline checks.
module tb_md_sched;
   logic        clk = 1'b0, reset = 1'b1, md_start_E = 1'b0, md_use_D = 1'b0;
   logic [2:0]  md_op_E = 3'd0;
   logic [31:0] rs_E = '0, rt_E = '0;
   logic [31:0] hi, lo;
   logic        busy, stall_md;
   int          checks = 0, errors = 0;

   md_sched dut (
      .clk(clk), .reset(reset), .md_start_E(md_start_E), .md_op_E(md_op_E),
      .rs_E(rs_E), .rt_E(rt_E), .md_use_D(md_use_D),
      .hi(hi), .lo(lo), .busy(busy), .stall_md(stall_md)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      md_start_E = 1'b1;
      md_op_E = op;
      rs_E = a;
      rt_E = b;
      tick();
      md_start_E = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      md_use_D = 1'b1;
      md_start_E = 1'b1;
      md_op_E = 3'd0;
      tick();
      tick();
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'd0); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'd0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_md); end
      reset = 1'b0;
      md_use_D = 1'b0;
      md_start_E = 1'b0;
      start(3'd0, 32'd5, 32'd7);
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre: got %b expected 1", busy); end
      reset = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      tick();
      reset = 1'b0;
      repeat (8) tick();
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL abort_hilo: got %h expected %h", {hi, lo}, 64'd0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_late: got %b expected 0", busy); end
   endtask

   task automatic test_mult();
      int n = 0;
      start(3'd0, 32'hFFFF_FFFE, 32'd3);
      for (int i = 0; i < 5; i++) begin
         if (busy === 1'b1) n++;
         checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL mult_early_%0d: got %h expected %h", i, {hi, lo}, 64'd0); end
         tick();
      end
      checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end: got %b expected 0", busy); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
      checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFF_FFFA); end
   endtask

   task automatic test_multu();
      start(3'd1, 32'hFFFF_FFFF, 32'd2);
      repeat (5) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy: got %b expected 0", busy); end
      checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi: got %h expected %h", hi, 32'h1); end
      checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected %h", lo, 32'hFFFF_FFFE); end
   endtask

   task automatic test_div();
      int n = 0;
      start(3'd2, 32'hFFFF_FFF9, 32'd2);
      for (int i = 0; i < 12; i++) begin
         if (busy === 1'b1) n++;
         if (i < 10) tick();
      end
      checks++; if (n != 10) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 10", n); end
      checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
      start(3'd3, 32'd5, 32'd0);
      repeat (9) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divz_busy_last: got %b expected 1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divz_busy_end: got %b expected 0", busy); end
      checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL divz_hilo: got %h expected %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD); end
      start(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      repeat (10) tick();
      checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h expected %h", lo, 32'h8000_0000); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL divovf_hi: got %h expected %h", hi, 32'd0); end
      start(3'd3, 32'd100, 32'd7);
      repeat (10) tick();
      checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_hilo: got %h expected %h", {hi, lo}, {32'd2, 32'd14}); end
      start(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (10) tick();
      checks++; if ({hi, lo} !== {32'd0, 32'd1}) begin errors++; $display("FAIL divu_max_hilo: got %h expected %h", {hi, lo}, {32'd0, 32'd1}); end
   endtask

   task automatic test_stall();
      int n = 0;
      md_use_D = 1'b1;
      md_start_E = 1'b1;
      md_op_E = 3'd0;
      rs_E = 32'd3;
      rt_E = 32'd4;
      #1;
      checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_start: got %b expected 1", stall_md); end
      tick();
      md_start_E = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (stall_md === 1'b1) n++;
         tick();
      end
      checks++; if (n != 5) begin errors++; $display("FAIL stall_busy_cycles: got %0d expected 5", n); end
      checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL stall_end: got %b expected 0", stall_md); end
      checks++; if ({hi, lo} !== 64'd12) begin errors++; $display("FAIL stall_hilo: got %h expected %h", {hi, lo}, 64'd12); end
      md_use_D = 1'b0;
   endtask

   task automatic test_mt();
      int b = 0;
      md_use_D = 1'b1;
      md_start_E = 1'b1;
      md_op_E = 3'd4;
      rs_E = 32'h1234_5678;
      #1;
      checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", stall_md); end
      tick();
      if (busy === 1'b1) b++;
      checks++; if ({hi, lo} !== {32'h1234_5678, 32'd12}) begin errors++; $display("FAIL mthi_hilo: got %h expected %h", {hi, lo}, {32'h1234_5678, 32'd12}); end
      md_op_E = 3'd5;
      rs_E = 32'h9ABC_DEF0;
      #1;
      checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL mtlo_stall: got %b expected 0", stall_md); end
      tick();
      if (busy === 1'b1) b++;
      md_start_E = 1'b0;
      md_use_D = 1'b0;
      checks++; if ({hi, lo} !== {32'h1234_5678, 32'h9ABC_DEF0}) begin errors++; $display("FAIL mtlo_hilo: got %h expected %h", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0}); end
      checks++; if (b != 0) begin errors++; $display("FAIL mt_busy: got %0d busy cycles expected 0", b); end
   endtask

   task automatic test_ignored();
      start(3'd6, 32'hDEAD_BEEF, 32'd1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsv_busy: got %b expected 0", busy); end
      checks++; if ({hi, lo} !== {32'h1234_5678, 32'h9ABC_DEF0}) begin errors++; $display("FAIL rsv_hilo: got %h expected %h", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0}); end
      start(3'd0, 32'd2, 32'd3);
      start(3'd1, 32'd7, 32'd7);
      start(3'd4, 32'hDEAD_BEEF, 32'd0);
      repeat (2) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_ign_busy: got %b expected 1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_ign_end: got %b expected 0", busy); end
      checks++; if ({hi, lo} !== 64'd6) begin errors++; $display("FAIL run_ign_hilo: got %h expected %h", {hi, lo}, 64'd6); end
      repeat (12) tick();
      checks++; if ({hi, lo} !== 64'd6 || busy !== 1'b0) begin errors++; $display("FAIL run_ign_late: got %h/%b expected %h/0", {hi, lo}, busy, 64'd6); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_stall();
      test_mt();
      test_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
